// File: rtl/branch_compare_seq_if.sv
// Handshake bundle for branch_compare_seq: operand issue, result return and flush.
// The master side issues comparisons and consumes results; the slave side is the comparator.
interface branch_compare_seq_if #(
  parameter int unsigned WIDTH = 32
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic             out_taken;

  modport master (
    output flush,
    output in_valid,
    output op,
    output a,
    output b,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_taken
  );

  modport slave (
    input  flush,
    input  in_valid,
    input  op,
    input  a,
    input  b,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_taken
  );
endinterface

// File: rtl/branch_compare_seq.sv
// Multi-cycle RISC-V branch comparator: walks WIDTH-bit operands CHUNK bits per cycle, MSB
// chunk first, and returns the taken/not-taken decision over a valid/ready handshake.
// Optional macro BRANCH_COMPARE_SEQ_EARLY_EXIT_EN finishes as soon as a differing chunk is seen.
module branch_compare_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input logic                clk,
  input logic                rst_n,
  branch_compare_seq_if.slave bus
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  localparam logic [2:0] OpEq  = 3'b000;
  localparam logic [2:0] OpNe  = 3'b001;
  localparam logic [2:0] OpLt  = 3'b100;
  localparam logic [2:0] OpGe  = 3'b101;
  localparam logic [2:0] OpLtu = 3'b110;
  localparam logic [2:0] OpGeu = 3'b111;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [2:0]       r_op;
  logic [IDXW-1:0]  r_idx;
  logic             r_diff;
  logic             r_lt;
  logic             r_taken;

  logic [CHUNK-1:0] w_ca;
  logic [CHUNK-1:0] w_cb;
  logic             w_signed;
  logic             w_chunk_lt;
  logic             w_diff_n;
  logic             w_lt_n;
  logic             w_last;
  logic             w_taken;

  // Compare the current chunk and fold it into the running diff/lt flags.
  always_comb begin
    w_ca       = CHUNK'(r_a >> (r_idx * CHUNK));
    w_cb       = CHUNK'(r_b >> (r_idx * CHUNK));
    // Only the sign-carrying top chunk of a signed compare is treated as two's complement.
    w_signed   = (r_idx == IDXW'(NCHUNK - 1)) && ((r_op == OpLt) || (r_op == OpGe));
    w_chunk_lt = w_signed ? ($signed(w_ca) < $signed(w_cb)) : (w_ca < w_cb);
    w_diff_n   = r_diff | (w_ca != w_cb);
    // Once a difference is recorded, lower chunks cannot change the ordering.
    w_lt_n     = r_diff ? r_lt : w_chunk_lt;
`ifdef BRANCH_COMPARE_SEQ_EARLY_EXIT_EN
    w_last     = (r_idx == '0) || w_diff_n;
`else
    w_last     = (r_idx == '0);
`endif
  end

  // Map the final diff/lt flags onto the branch condition selected by funct3.
  always_comb begin
    w_taken = 1'b0;
    unique case (r_op)
      OpEq:          w_taken = ~w_diff_n;
      OpNe:          w_taken = w_diff_n;
      OpLt,  OpLtu:  w_taken = w_lt_n;
      OpGe,  OpGeu:  w_taken = ~w_lt_n;
      default:       w_taken = 1'b0;
    endcase
  end

  // Control FSM with registered operands, flags and result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= '0;
      r_idx   <= '0;
      r_diff  <= 1'b0;
      r_lt    <= 1'b0;
      r_taken <= 1'b0;
    end else if (bus.flush) begin
      // Flush beats any simultaneous capture or result handshake.
      r_state <= StIdle;
      r_idx   <= '0;
      r_diff  <= 1'b0;
      r_lt    <= 1'b0;
      r_taken <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (bus.in_valid) begin
            r_a     <= bus.a;
            r_b     <= bus.b;
            r_op    <= bus.op;
            r_idx   <= IDXW'(NCHUNK - 1);
            r_diff  <= 1'b0;
            r_lt    <= 1'b0;
            r_state <= StRun;
          end
        end
        StRun: begin
          r_diff <= w_diff_n;
          r_lt   <= w_lt_n;
          if (w_last) begin
            r_taken <= w_taken;
            r_state <= StDone;
          end else begin
            r_idx <= r_idx - 1'b1;
          end
        end
        StDone: begin
          if (bus.out_ready) begin
            r_taken <= 1'b0;
            r_state <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == StIdle);
  assign bus.out_valid = (r_state == StDone);
  assign bus.out_taken = r_taken;

endmodule

// File: tb/tb_branch_compare_seq.sv
// Scoreboard bench for branch_compare_seq (WIDTH=32, CHUNK=8): directed corner cases then
// randomized traffic with random backpressure and flushes, checked against a full-width model.
module tb_branch_compare_seq;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned CHUNK = 8;
  localparam int unsigned NCH   = WIDTH / CHUNK;

  logic clk;
  logic rst_n;

  branch_compare_seq_if #(.WIDTH(WIDTH)) bus ();

  branch_compare_seq #(
    .WIDTH(WIDTH),
    .CHUNK(CHUNK)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic taken;
    int   lat;
    int   acc;
    bit   seen;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  bit   force_low = 0;
  bit   rnd_ready = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic report(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at cycle %0d", nm, act, req, cyc);
    end
  endtask

  // Reference model: full-width arithmetic on the architectural values.
  function automatic logic model_taken(input logic [2:0] o, input logic [31:0] x, y);
    case (o)
      3'b000:  return x == y;
      3'b001:  return x != y;
      3'b100:  return $signed(x) < $signed(y);
      3'b101:  return $signed(x) >= $signed(y);
      3'b110:  return x < y;
      3'b111:  return x >= y;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int model_lat(input logic [31:0] x, y);
`ifdef BRANCH_COMPARE_SEQ_EARLY_EXIT_EN
    for (int k = 1; k <= NCH; k++) begin
      if (x[WIDTH-k*CHUNK +: CHUNK] != y[WIDTH-k*CHUNK +: CHUNK]) return k;
    end
`endif
    return NCH;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one comparison; the expectation is queued in the cycle whose edge accepts it.
  task automatic issue(input logic [2:0] o, input logic [31:0] x, y);
    int  n  = 0;
    bit  ok = 0;
    exp_t e;
    bus.op = o;
    bus.a = x;
    bus.b = y;
    bus.in_valid = 1'b1;
    while (!ok && n < 100) begin
      @(negedge clk);
      if (bus.in_ready && !bus.flush) begin
        e.taken = model_taken(o, x, y);
        e.lat   = model_lat(x, y);
        e.acc   = cyc + 1;
        e.seen  = 0;
        q.push_back(e);
        ok = 1;
      end
      n++;
    end
    if (!ok) report("accept_timeout", 32'd0, 32'd1);
    step();
    bus.in_valid = 1'b0;
    bus.a = $urandom;
    bus.b = $urandom;
    bus.op = 3'($urandom);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (q.size() != 0 && n < 60) begin
      step();
      n++;
    end
    if (q.size() != 0) begin
      report("drain_timeout", 32'(q.size()), 32'd0);
      q.delete();
    end
  endtask

  // Result-side consumer readiness.
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      step();
      bus.out_ready = force_low ? 1'b0 : (rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1);
    end
  end

  // Monitor: compares presented results against the scoreboard head.
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (bus.in_ready && bus.out_valid) report("ready_valid_overlap", 32'd1, 32'd0);
      if (bus.out_valid) begin
        if (q.size() == 0) begin
          report("stale_out_valid", 32'd1, 32'd0);
        end else begin
          report("taken", 32'(bus.out_taken), 32'(q[0].taken));
          if (!q[0].seen) begin
            report("latency", 32'(cyc - q[0].acc), 32'(q[0].lat));
            q[0].seen = 1;
          end
        end
      end else begin
        report("idle_taken_low", 32'(bus.out_taken), 32'd0);
      end
      if (bus.flush) q.delete();
      else if (bus.out_valid && bus.out_ready && q.size() != 0) void'(q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] x, y;
    logic [2:0]  o;
    int          n;
    rst_n = 1'b0;
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.op = '0;
    bus.a = '0;
    bus.b = '0;
    #3;
    report("rst_in_ready", 32'(bus.in_ready), 32'd1);
    report("rst_out_valid", 32'(bus.out_valid), 32'd0);
    report("rst_out_taken", 32'(bus.out_taken), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    step();

    // Equality, signed/unsigned ordering, illegal op, early-exit pattern.
    issue(3'b000, 32'h1234_5678, 32'h1234_5678);
    issue(3'b001, 32'h1234_5678, 32'h1234_5678);
    issue(3'b100, 32'hFFFF_FFFD, 32'd10);
    issue(3'b110, 32'hFFFF_FFFD, 32'd10);
    issue(3'b101, 32'hFFFF_FFF9, 32'hFFFF_FFFD);
    issue(3'b110, 32'h0100_0000, 32'h0200_0000);
    issue(3'b010, 32'd5, 32'd5);
    issue(3'b011, 32'd5, 32'd7);
    wait_drain();

    // Backpressure on a low-chunk difference: result must hold while out_ready is low.
    force_low = 1;
    step();
    issue(3'b111, 32'h0000_0005, 32'h0000_0007);
    n = 0;
    while (!bus.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    report("bp_valid_seen", 32'(bus.out_valid), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      report("bp_valid_hold", 32'(bus.out_valid), 32'd1);
      report("bp_taken_hold", 32'(bus.out_taken), 32'd0);
      report("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
    end
    force_low = 0;
    step();
    wait_drain();
    step();
    report("after_handshake_in_ready", 32'(bus.in_ready), 32'd1);

    // Flush in the second RUN cycle.
    issue(3'b000, 32'hAAAA_5555, 32'hAAAA_5555);
    step();
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    report("flush_in_ready", 32'(bus.in_ready), 32'd1);
    report("flush_out_valid", 32'(bus.out_valid), 32'd0);
    repeat (6) step();

    // Flush coincident with in_valid in IDLE: nothing may be captured.
    bus.op = 3'b000;
    bus.a = 32'd1;
    bus.b = 32'd1;
    bus.in_valid = 1'b1;
    bus.flush = 1'b1;
    step();
    bus.in_valid = 1'b0;
    bus.flush = 1'b0;
    report("flush_vs_in_valid", 32'(bus.in_ready), 32'd1);
    repeat (6) step();

    // Asynchronous reset in the middle of RUN.
    issue(3'b100, 32'h8000_0000, 32'h7FFF_FFFF);
    step();
    rst_n = 1'b0;
    #1;
    report("async_rst_in_ready", 32'(bus.in_ready), 32'd1);
    report("async_rst_out_valid", 32'(bus.out_valid), 32'd0);
    q.delete();
    step();
    rst_n = 1'b1;
    repeat (6) step();

    // Randomized traffic with random backpressure and occasional flushes.
    rnd_ready = 1;
    for (int t = 0; t < 300; t++) begin
      x = $urandom;
      y = x;
      case ($urandom_range(0, 3))
        0: y = $urandom;
        1: y[$urandom_range(0, 31)] = ~y[$urandom_range(0, 31)];
        2: for (int k = 0; k < 4; k++) if ($urandom_range(0, 1) == 1) y[k*8 +: 8] = 8'($urandom);
        default: ;
      endcase
      if ($urandom_range(0, 7) == 0) y = x;
      case ($urandom_range(0, 12))
        0, 1:    o = 3'b000;
        2, 3:    o = 3'b001;
        4, 5:    o = 3'b100;
        6, 7:    o = 3'b101;
        8, 9:    o = 3'b110;
        10, 11:  o = 3'b111;
        default: o = 3'($urandom_range(2, 3));
      endcase
      issue(o, x, y);
      if ($urandom_range(0, 11) == 0) begin
        repeat ($urandom_range(0, 5)) step();
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        report("rnd_flush_in_ready", 32'(bus.in_ready), 32'd1);
      end
    end
    rnd_ready = 0;
    wait_drain();
    repeat (4) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
